// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the MEMCTRL two-port arbiter.
// Holds the sequencer state encoding and the MEMCTRL bus idle levels.
package mem_arb_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CMD  = 3'd1,
    GAP  = 3'd2,
    WAIT = 3'd3,
    RESP = 3'd4
  } state_t;

  localparam logic CE_IDLE  = 1'b0;
  localparam logic CSB_IDLE = 1'b1;
  localparam logic WEB_IDLE = 1'b1;
  localparam logic OEB_IDLE = 1'b1;

  function automatic logic [1:0] port_onehot(input logic id);
    if (id) begin
      return 2'b10;
    end else begin
      return 2'b01;
    end
  endfunction

endpackage

// File: rtl/memctrl_arbiter_if.sv
// Requester-port and MEMCTRL-bus interfaces of the arbiter.
// master drives the request (or strobe) side, slave answers it.
interface memctrl_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic              done;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input ack, done, rdata);
  modport slave  (input req, we, addr, wdata, output ack, done, rdata);
endinterface

interface memctrl_bus_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_idata;
  logic              m_ce;
  logic              m_csb;
  logic              m_web;
  logic              m_oeb;
  logic [DATA_W-1:0] m_odata;

  modport master (output m_addr, m_idata, m_ce, m_csb, m_web, m_oeb, input m_odata);
  modport slave  (input m_addr, m_idata, m_ce, m_csb, m_web, m_oeb, output m_odata);
endinterface

// File: rtl/memctrl_arbiter_rr_arb2.sv
// Two-requester round-robin grant logic, purely combinational.
// On a tie the port that was not granted last wins.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  // Pick the winner id and expand it to a one-hot grant.
  always_comb begin
    gnt_id = 1'b0;
    case (req)
      2'b01:   gnt_id = 1'b0;
      2'b10:   gnt_id = 1'b1;
      2'b11:   gnt_id = ~last;
      default: gnt_id = 1'b0;
    endcase
    if (|req) begin
      gnt = port_onehot(gnt_id);
    end else begin
      gnt = 2'b00;
    end
  end

endmodule

// File: rtl/memctrl_arbiter.sv
// memctrl_arbiter: serialises two request ports onto MEMCTRL's one-cycle strobe
// protocol and returns read data to the owning port after READ_LAT cycles.
module memctrl_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int READ_LAT = 2
) (
  input  logic             clk,
  input  logic             rstn,
  memctrl_arbiter_if.slave p0,
  memctrl_arbiter_if.slave p1,
  memctrl_bus_if.master    mem,
  output logic             busy
);

  localparam int CNT_W = $clog2(READ_LAT + 1);

  state_t            state_r;
  state_t            state_nxt_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_nxt_s;
  logic              last_r;
  logic              owner_r;
  logic              we_r;

  logic [1:0]        req_s;
  logic [1:0]        gnt_s;
  logic              gnt_id_s;
  logic              grant_s;
  logic              lat_done_s;
  logic              win_we_s;
  logic [ADDR_W-1:0] win_addr_s;
  logic [DATA_W-1:0] win_wdata_s;

  logic [1:0]        ack_r;
  logic [1:0]        ack_nxt_s;
  logic [1:0]        done_r;
  logic [1:0]        done_nxt_s;
  logic              m_ce_r;
  logic              m_ce_nxt_s;
  logic              m_csb_r;
  logic              m_csb_nxt_s;
  logic              m_web_r;
  logic              m_web_nxt_s;
  logic              m_oeb_r;
  logic              m_oeb_nxt_s;
  logic [ADDR_W-1:0] m_addr_r;
  logic [ADDR_W-1:0] m_addr_nxt_s;
  logic [DATA_W-1:0] m_idata_r;
  logic [DATA_W-1:0] m_idata_nxt_s;
  logic [DATA_W-1:0] rdata0_r;
  logic [DATA_W-1:0] rdata1_r;
  logic              busy_r;

  assign req_s       = {p1.req, p0.req};
  assign win_we_s    = gnt_id_s ? p1.we    : p0.we;
  assign win_addr_s  = gnt_id_s ? p1.addr  : p0.addr;
  assign win_wdata_s = gnt_id_s ? p1.wdata : p0.wdata;
  assign grant_s     = (state_r == IDLE) && (|req_s);
  assign lat_done_s  = (state_r == WAIT) && (cnt_r == CNT_W'(1));

  rr_arb2 u_rr_arb2 (
    .req    (req_s),
    .last   (last_r),
    .gnt    (gnt_s),
    .gnt_id (gnt_id_s)
  );

  // State register and read-latency counter.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state logic; the counter is loaded on leaving CMD for a read.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (grant_s) begin
          state_nxt_s = CMD;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      CMD: begin
        if (we_r) begin
          state_nxt_s = GAP;
        end else begin
          state_nxt_s = WAIT;
          cnt_nxt_s   = CNT_W'(READ_LAT);
        end
      end
      GAP:  state_nxt_s = IDLE;
      WAIT: begin
        if (lat_done_s) begin
          state_nxt_s = RESP;
        end else begin
          cnt_nxt_s = cnt_r - CNT_W'(1);
        end
      end
      RESP:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output decode: values the output registers take at the next edge.
  always_comb begin
    ack_nxt_s     = 2'b00;
    done_nxt_s    = 2'b00;
    m_ce_nxt_s    = CE_IDLE;
    m_csb_nxt_s   = CSB_IDLE;
    m_web_nxt_s   = WEB_IDLE;
    m_oeb_nxt_s   = OEB_IDLE;
    m_addr_nxt_s  = m_addr_r;
    m_idata_nxt_s = {DATA_W{1'b0}};
    if (grant_s) begin
      ack_nxt_s    = gnt_s;
      m_ce_nxt_s   = 1'b1;
      m_csb_nxt_s  = 1'b0;
      m_web_nxt_s  = ~win_we_s;
      m_oeb_nxt_s  = win_we_s;
      m_addr_nxt_s = win_addr_s;
      if (win_we_s) begin
        m_idata_nxt_s = win_wdata_s;
      end else begin
        m_idata_nxt_s = {DATA_W{1'b0}};
      end
    end else if (((state_r == CMD) && we_r) || lat_done_s) begin
      done_nxt_s = port_onehot(owner_r);
    end else begin
      done_nxt_s = 2'b00;
    end
  end

  // Output and grant-bookkeeping registers; reset returns the bus to idle levels.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ack_r     <= 2'b00;
      done_r    <= 2'b00;
      m_ce_r    <= CE_IDLE;
      m_csb_r   <= CSB_IDLE;
      m_web_r   <= WEB_IDLE;
      m_oeb_r   <= OEB_IDLE;
      m_addr_r  <= {ADDR_W{1'b0}};
      m_idata_r <= {DATA_W{1'b0}};
      busy_r    <= 1'b0;
      last_r    <= 1'b1;
      owner_r   <= 1'b0;
      we_r      <= 1'b0;
    end else begin
      ack_r     <= ack_nxt_s;
      done_r    <= done_nxt_s;
      m_ce_r    <= m_ce_nxt_s;
      m_csb_r   <= m_csb_nxt_s;
      m_web_r   <= m_web_nxt_s;
      m_oeb_r   <= m_oeb_nxt_s;
      m_addr_r  <= m_addr_nxt_s;
      m_idata_r <= m_idata_nxt_s;
      busy_r    <= (state_nxt_s != IDLE);
      if (grant_s) begin
        last_r  <= gnt_id_s;
        owner_r <= gnt_id_s;
        we_r    <= win_we_s;
      end else begin
        last_r  <= last_r;
        owner_r <= owner_r;
        we_r    <= we_r;
      end
    end
  end

  // Per-port read data, loaded from MEMCTRL at the edge closing the last WAIT cycle.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rdata0_r <= {DATA_W{1'b0}};
      rdata1_r <= {DATA_W{1'b0}};
    end else begin
      if (lat_done_s && !owner_r) begin
        rdata0_r <= mem.m_odata;
      end else begin
        rdata0_r <= rdata0_r;
      end
      if (lat_done_s && owner_r) begin
        rdata1_r <= mem.m_odata;
      end else begin
        rdata1_r <= rdata1_r;
      end
    end
  end

  assign p0.ack      = ack_r[0];
  assign p1.ack      = ack_r[1];
  assign p0.done     = done_r[0];
  assign p1.done     = done_r[1];
  assign p0.rdata    = rdata0_r;
  assign p1.rdata    = rdata1_r;
  assign mem.m_ce    = m_ce_r;
  assign mem.m_csb   = m_csb_r;
  assign mem.m_web   = m_web_r;
  assign mem.m_oeb   = m_oeb_r;
  assign mem.m_addr  = m_addr_r;
  assign mem.m_idata = m_idata_r;
  assign busy        = busy_r;

endmodule
